// File: rtl/aes_iter_engine_if.sv
// Handshake bundle between the host block buffer, the AES engine and the ciphertext sink.
interface aes_iter_engine_if #(
  parameter int unsigned KEY_BITS = 128
) ();
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        in_text;
  logic [KEY_BITS-1:0] in_key;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out_text;
  logic                busy;

  modport slave  (input  in_valid, in_text, in_key, out_ready,
                  output in_ready, out_valid, out_text, busy);
  modport master (output in_valid, in_text, in_key, out_ready,
                  input  in_ready, out_valid, out_text, busy);
endinterface

// File: rtl/aes_iter_engine.sv
// Iterative AES encryption engine: one round per clock, round keys expanded on the fly.
// Supports AES-128 (10 rounds) and AES-256 (14 rounds) via KEY_BITS.
module aes_iter_engine #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic             clk,
  input  logic             rst,
  aes_iter_engine_if.slave bus
);
  localparam int unsigned NR   = (KEY_BITS == 128) ? 10 : 14;
  localparam int unsigned RC_W = 4;

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_iter_engine: KEY_BITS must be 128 or 256");
  end

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [RC_W-1:0] n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < 11; i++) if (n > RC_W'(i)) r = xtime(r);
    return (n == '0 || n > RC_W'(10)) ? 8'h00 : r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
    return r;
  endfunction

  // Byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  // Chain the four words of the key Nk words back with the transformed word.
  function automatic logic [127:0] expand(input logic [127:0] prev, input logic [31:0] temp);
    logic [31:0] w0, w1, w2, w3;
    w0 = prev[127:96] ^ temp;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_e          st_q, st_d;
  logic [3:0]      round_q, round_d;
  logic [127:0]    s_q, s_d;
  logic [127:0]    ka_q, ka_d;
  logic [127:0]    kb_q, kb_d;
  logic            out_valid_q, out_valid_d;
  logic [127:0]    out_text_q, out_text_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic [31:0]     temp;
  logic [127:0]    rk, sr;

  always_comb begin
    st_d        = st_q;
    round_d     = round_q;
    s_d         = s_q;
    ka_d        = ka_q;
    kb_d        = kb_q;
    out_valid_d = out_valid_q;
    out_text_d  = out_text_q;
    rk          = kb_q;

    // ka_q holds rk[i-2] and kb_q holds rk[i-1]; AES-128 only needs kb_q.
    if (KEY_BITS == 256) begin
      if (round_q[0]) temp = sub_word(kb_q[31:0]);
      else            temp = sub_word({kb_q[23:0], kb_q[31:24]}) ^ {rcon(round_q >> 1), 24'h0};
      if (round_q != 4'd1) rk = expand(ka_q, temp);
    end else begin
      temp = sub_word({kb_q[23:0], kb_q[31:24]}) ^ {rcon(round_q), 24'h0};
      rk   = expand(kb_q, temp);
    end
    sr = shift_rows(sub_bytes(s_q));

    case (st_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.in_text ^ bus.in_key[KEY_BITS-1 -: 128];
          ka_d    = bus.in_key[KEY_BITS-1 -: 128];
          kb_d    = bus.in_key[127:0];
          round_d = 4'd1;
          st_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (round_q == 4'(NR)) begin
          s_d         = sr ^ rk;
          out_text_d  = sr ^ rk;
          out_valid_d = 1'b1;
          round_d     = '0;
          st_d        = S_DONE;
        end else begin
          s_d     = mix_columns(sr) ^ rk;
          round_d = round_q + 4'd1;
        end
        // AES-256 round 1 consumes the loaded second key half without generating.
        if (KEY_BITS == 128 || round_q != 4'd1) begin
          ka_d = kb_q;
          kb_d = rk;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          st_d        = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase

    in_ready_d = (st_d == S_IDLE);
    busy_d     = (st_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= S_IDLE;
      round_q     <= '0;
      s_q         <= '0;
      ka_q        <= '0;
      kb_q        <= '0;
      out_valid_q <= 1'b0;
      out_text_q  <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      round_q     <= round_d;
      s_q         <= s_d;
      ka_q        <= ka_d;
      kb_q        <= kb_d;
      out_valid_q <= out_valid_d;
      out_text_q  <= out_text_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_text  = out_text_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_aes_iter_engine.sv
// Bench for aes_iter_engine: AES-128 and AES-256 instances against known answers
// and a FIPS-style reference cipher with an S-box derived from GF(2^8) inversion.
module tb_aes_iter_engine;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  aes_iter_engine_if #(.KEY_BITS(128)) if128 ();
  aes_iter_engine_if #(.KEY_BITS(256)) if256 ();

  aes_iter_engine #(.KEY_BITS(128)) dut128 (.clk(clk), .rst(rst), .bus(if128.slave));
  aes_iter_engine #(.KEY_BITS(256)) dut256 (.clk(clk), .rst(rst), .bus(if256.slave));

  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Key in the low kbits of key; full schedule first, then the rounds.
  function automatic logic [127:0] aes_ref(logic [127:0] pt, logic [255:0] key, int kbits);
    int nk, nr;
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   b [16];
    logic [7:0]   n [16];
    logic [127:0] o;
    nk = kbits / 32;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*(nk-1-i) +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k < 16; k++) b[k] = pt[127-8*k -: 8];
    for (int rnd = 0; rnd <= nr; rnd++) begin
      if (rnd > 0) begin
        for (int k = 0; k < 16; k++) b[k] = sbox_t[b[k]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) n[4*c+r] = b[4*((c+r)%4)+r];
        if (rnd < nr) begin
          for (int c = 0; c < 4; c++) begin
            b[4*c+0] = gmul(n[4*c], 8'h02) ^ gmul(n[4*c+1], 8'h03) ^ n[4*c+2] ^ n[4*c+3];
            b[4*c+1] = n[4*c] ^ gmul(n[4*c+1], 8'h02) ^ gmul(n[4*c+2], 8'h03) ^ n[4*c+3];
            b[4*c+2] = n[4*c] ^ n[4*c+1] ^ gmul(n[4*c+2], 8'h02) ^ gmul(n[4*c+3], 8'h03);
            b[4*c+3] = gmul(n[4*c], 8'h03) ^ n[4*c+1] ^ n[4*c+2] ^ gmul(n[4*c+3], 8'h02);
          end
        end else begin
          for (int k = 0; k < 16; k++) b[k] = n[k];
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) b[4*c+r] = b[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = b[k];
    return o;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic iready(bit w); return w ? if256.in_ready : if128.in_ready; endfunction
  function automatic logic ovalid(bit w); return w ? if256.out_valid : if128.out_valid; endfunction
  function automatic logic obusy(bit w); return w ? if256.busy : if128.busy; endfunction
  function automatic logic [127:0] otext(bit w); return w ? if256.out_text : if128.out_text; endfunction

  task automatic drive(bit w, logic v, logic [127:0] pt, logic [255:0] key);
    if (w) begin
      if256.in_valid = v; if256.in_text = pt; if256.in_key = key;
    end else begin
      if128.in_valid = v; if128.in_text = pt; if128.in_key = key[127:0];
    end
  endtask

  task automatic set_oready(bit w, logic v);
    if (w) if256.out_ready = v; else if128.out_ready = v;
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(bit w, logic [127:0] pt, logic [255:0] key);
    int k;
    k = 0;
    while (!iready(w) && k < 40) begin @(negedge clk); k++; end
    chk("send_ready", 128'(iready(w)), 128'(1));
    drive(w, 1'b1, pt, key);
    @(negedge clk);
    drive(w, 1'b0, ~pt, ~key);
    chk("send_busy", 128'(obusy(w)), 128'(1));
  endtask

  // hold < 0: out_ready raised before the result appears.
  task automatic recv(bit w, logic [127:0] exp, string tag, int lat, int hold);
    int k;
    k = 0;
    if (hold < 0) set_oready(w, 1'b1);
    while (!ovalid(w) && k < 40) begin @(negedge clk); k++; end
    chk({tag, "_valid"}, 128'(ovalid(w)), 128'(1));
    chk({tag, "_lat"}, 128'(k), 128'(lat));
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_text"}, otext(w), exp);
      chk({tag, "_hold_rdy"}, 128'(iready(w)), 128'(0));
      drive(w, 1'b1, {4{32'hdead_beef}}, {8{32'h0bad_f00d}});
      @(negedge clk);
    end
    chk({tag, "_text"}, otext(w), exp);
    drive(w, 1'b0, '0, '0);
    set_oready(w, 1'b1);
    @(negedge clk);
    set_oready(w, 1'b0);
    chk({tag, "_drop"}, 128'(ovalid(w)), 128'(0));
    chk({tag, "_idle"}, 128'(iready(w)), 128'(1));
  endtask

  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2  = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] K2   = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] CT2  = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [255:0] K3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] q [$];
    logic [127:0] pt;
    logic [255:0] key;
    bit           w;
    int           hold;

    build_sbox();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    set_oready(1'b0, 1'b0);
    set_oready(1'b1, 1'b0);
    #2;
    chk("rst_in_ready", 128'(iready(0)), 128'(1));
    chk("rst_out_valid", 128'(ovalid(0)), 128'(0));
    chk("rst_out_text", otext(0), 128'(0));
    chk("rst_busy", 128'(obusy(0)), 128'(0));
    chk("rst256_in_ready", 128'(iready(1)), 128'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send(1'b0, PT1, {128'h0, K1});
    recv(1'b0, CT1, "kat128_a", 10, 0);
    send(1'b0, PT2, {128'h0, K2});
    recv(1'b0, CT2, "kat128_b", 10, 0);
    send(1'b1, PT1, K3);
    recv(1'b1, CT3, "kat256", 14, 0);

    // Backpressure with stray in_valid traffic during DONE.
    send(1'b0, PT2, {128'h0, K2});
    recv(1'b0, CT2, "bp", 10, 20);
    @(negedge clk);
    chk("bp_no_stray_busy", 128'(obusy(0)), 128'(0));
    chk("bp_no_stray_rdy", 128'(iready(0)), 128'(1));

    // Reset in the middle of round 5.
    send(1'b0, PT1, {128'h0, K1});
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(iready(0)), 128'(1));
    chk("mid_rst_out_valid", 128'(ovalid(0)), 128'(0));
    chk("mid_rst_out_text", otext(0), 128'(0));
    chk("mid_rst_busy", 128'(obusy(0)), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", 128'(ovalid(0)), 128'(0));
    end
    send(1'b0, PT1, {128'h0, K1});
    recv(1'b0, CT1, "post_rst", 10, 0);

    // Random blocks and keys with random gaps on both handshakes.
    for (int n = 0; n < 16; n++) begin
      w = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) pt[32*i +: 32] = $urandom;
      for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
      if (!w) key[255:128] = '0;
      q.push_back(aes_ref(pt, key, w ? 256 : 128));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(w, pt, key);
      hold = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 4));
      recv(w, q.pop_front(), "rand", w ? 14 : 10, hold);
    end
    chk("rand_queue_empty", 128'(q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
